// File: rtl/beep_pattern_gen_pkg.sv
// Shared definitions for the beep pattern generator: state encoding,
// default timing constants and the phase-counter width helper.
package beep_pattern_gen_pkg;

    localparam logic [19:0] DEF_ON_CNT  = 20'd4;
    localparam logic [19:0] DEF_OFF_CNT = 20'd3;
    localparam int          DEF_NUM_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // Phase counter width: clog2(max(on, off)) + 1.
    function automatic int phase_width(input logic [19:0] a, input logic [19:0] b);
        logic [19:0] m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/beep_pattern_gen_phase_timer.sv
// Loadable down-counter with a terminal-count flag. A load starts a phase
// of (load value + 1) cycles; tc_o is high in the last cycle of the phase.
module beep_pattern_gen_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load, load beats the decrement, hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/beep_pattern_gen.sv
// Burst pulse generator: an accepted start produces num pulses of ON_CNT
// high cycles separated by OFF_CNT low cycles, then a one-cycle done.
// Handshake: start/num are taken only in IDLE (busy=0); stop aborts any
// burst without done; all outputs are registered.
module beep_pattern_gen
    import beep_pattern_gen_pkg::*;
#(
    parameter logic [19:0] ON_CNT  = DEF_ON_CNT,
    parameter logic [19:0] OFF_CNT = DEF_OFF_CNT,
    parameter int          NUM_W   = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic             stop,
    output logic             busy,
    output logic             beep_out,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int PW = phase_width(ON_CNT, OFF_CNT);
    localparam logic [PW-1:0] ON_LOAD  = PW'(ON_CNT - 20'd1);
    localparam logic [PW-1:0] OFF_LOAD = PW'(OFF_CNT - 20'd1);

    state_t           state_q;
    logic [NUM_W-1:0] rem_q;
    logic             busy_q;
    logic             beep_q;
    logic             done_q;

    logic             tmr_load;
    logic             tmr_clear;
    logic [PW-1:0]    tmr_val;
    logic             tmr_tc;

    // Timer control: reload on every phase entry, clear on abort or burst end.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_clear = stop;
        tmr_val   = ON_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (!stop && start && (num != '0)) begin
                    tmr_load = 1'b1;
                end
            end
            ST_ON: begin
                if (!stop && tmr_tc) begin
                    if (rem_q > NUM_W'(1)) begin
                        tmr_load = 1'b1;
                        tmr_val  = OFF_LOAD;
                    end else begin
                        tmr_clear = 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (!stop && tmr_tc) begin
                    tmr_load = 1'b1;
                end
            end
            default: tmr_clear = 1'b1;
        endcase
    end

    beep_pattern_gen_phase_timer #(
        .W(PW)
    ) u_phase_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // Burst FSM with registered busy/beep/done; stop wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            beep_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!stop && start) begin
                        if (num != '0) begin
                            state_q <= ST_ON;
                            rem_q   <= num;
                            busy_q  <= 1'b1;
                            beep_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        beep_q  <= 1'b0;
                    end else if (tmr_tc) begin
                        beep_q <= 1'b0;
                        if (rem_q > NUM_W'(1)) begin
                            state_q <= ST_OFF;
                            rem_q   <= rem_q - NUM_W'(1);
                        end else begin
                            state_q <= ST_IDLE;
                            rem_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        beep_q  <= 1'b0;
                    end else if (tmr_tc) begin
                        state_q <= ST_ON;
                        beep_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rem_q   <= '0;
                    busy_q  <= 1'b0;
                    beep_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign beep_out  = beep_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Directed bench for beep_pattern_gen with default timing (ON=4, OFF=3).
// Cycle 0 is the cycle in which start is held high; cycle c is observed at
// the falling edge c cycles later.
module tb_beep_pattern_gen;
  import beep_pattern_gen_pkg::*;

  localparam int ON  = int'(DEF_ON_CNT);
  localparam int OFF = int'(DEF_OFF_CNT);

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] num;
  logic       stop;
  logic       busy;
  logic       beep_out;
  logic       done;
  logic [1:0] state_dbg;

  int checks;
  int errors;

  logic       ob_beep [0:63];
  logic       ob_busy [0:63];
  logic       ob_done [0:63];
  logic [1:0] ob_state[0:63];

  beep_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num       (num),
    .stop      (stop),
    .busy      (busy),
    .beep_out  (beep_out),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model of one burst whose start was held in cycle 0
  function automatic int m_last(input int n);
    return n * ON + (n - 1) * OFF;
  endfunction

  function automatic logic m_beep(input int c, input int n);
    if (n == 0 || c < 1 || c > m_last(n)) return 1'b0;
    return ((c - 1) % (ON + OFF)) < ON;
  endfunction

  function automatic logic m_busy(input int c, input int n);
    return (n != 0) && (c >= 1) && (c <= m_last(n));
  endfunction

  function automatic logic m_done(input int c, input int n);
    if (n == 0) return c == 1;
    return c == m_last(n) + 1;
  endfunction

  function automatic logic [1:0] m_state(input logic b, input logic bz);
    if (b) return ST_ON;
    if (bz) return ST_OFF;
    return ST_IDLE;
  endfunction

  // driver: hold start with num for one cycle (cycle 0)
  task automatic kick(input logic [3:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    num   = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // record outputs for cycles 1..len; optionally drive start/stop/num
  // during cycle inj_c (released one cycle later)
  task automatic observe(input int len, input int inj_c, input logic inj_start,
                         input logic inj_stop, input logic [3:0] inj_num);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      ob_beep[c]  = beep_out;
      ob_busy[c]  = busy;
      ob_done[c]  = done;
      ob_state[c] = state_dbg;
      if (c == inj_c) begin
        start = inj_start;
        stop  = inj_stop;
        num   = inj_num;
      end else if (c == inj_c + 1) begin
        start = 1'b0;
        stop  = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    if (beep_out !== 1'b0) begin errors++; $display("FAIL reset beep got %b exp 0", beep_out); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", done); end
    if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset state got %0d exp 0", state_dbg); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic(input string tag);
    logic e_b, e_bz, e_d;
    kick(4'd2);
    observe(16, 0, 1'b0, 1'b0, 4'd0);
    for (int c = 1; c <= 16; c++) begin
      e_b  = m_beep(c, 2);
      e_bz = m_busy(c, 2);
      e_d  = m_done(c, 2);
      checks += 4;
      if (ob_beep[c] !== e_b) begin errors++; $display("FAIL %s beep cyc %0d got %b exp %b", tag, c, ob_beep[c], e_b); end
      if (ob_busy[c] !== e_bz) begin errors++; $display("FAIL %s busy cyc %0d got %b exp %b", tag, c, ob_busy[c], e_bz); end
      if (ob_done[c] !== e_d) begin errors++; $display("FAIL %s done cyc %0d got %b exp %b", tag, c, ob_done[c], e_d); end
      if (ob_state[c] !== m_state(e_b, e_bz)) begin
        errors++; $display("FAIL %s state cyc %0d got %0d exp %0d", tag, c, ob_state[c], m_state(e_b, e_bz));
      end
    end
  endtask

  task automatic test_zero();
    kick(4'd0);
    observe(6, 0, 1'b0, 1'b0, 4'd0);
    for (int c = 1; c <= 6; c++) begin
      checks += 3;
      if (ob_done[c] !== (c == 1)) begin errors++; $display("FAIL zero done cyc %0d got %b exp %b", c, ob_done[c], c == 1); end
      if (ob_beep[c] !== 1'b0) begin errors++; $display("FAIL zero beep cyc %0d got %b exp 0", c, ob_beep[c]); end
      if (ob_busy[c] !== 1'b0) begin errors++; $display("FAIL zero busy cyc %0d got %b exp 0", c, ob_busy[c]); end
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic prev;
    kick(4'd3);
    observe(24, 6, 1'b1, 1'b0, 4'd5);
    pulses = 0;
    prev   = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (ob_beep[c] && !prev) pulses++;
      prev = ob_beep[c];
      checks += 3;
      if (ob_beep[c] !== m_beep(c, 3)) begin errors++; $display("FAIL ignore beep cyc %0d got %b exp %b", c, ob_beep[c], m_beep(c, 3)); end
      if (ob_busy[c] !== m_busy(c, 3)) begin errors++; $display("FAIL ignore busy cyc %0d got %b exp %b", c, ob_busy[c], m_busy(c, 3)); end
      if (ob_done[c] !== (c == 19)) begin errors++; $display("FAIL ignore done cyc %0d got %b exp %b", c, ob_done[c], c == 19); end
    end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL ignore pulse_count got %0d exp 3", pulses); end
  endtask

  task automatic test_stop();
    logic e_b, e_bz;
    kick(4'd2);
    observe(16, 6, 1'b0, 1'b1, 4'd0);
    for (int c = 1; c <= 16; c++) begin
      e_b  = (c <= 6) ? m_beep(c, 2) : 1'b0;
      e_bz = (c <= 6) ? m_busy(c, 2) : 1'b0;
      checks += 4;
      if (ob_beep[c] !== e_b) begin errors++; $display("FAIL stop beep cyc %0d got %b exp %b", c, ob_beep[c], e_b); end
      if (ob_busy[c] !== e_bz) begin errors++; $display("FAIL stop busy cyc %0d got %b exp %b", c, ob_busy[c], e_bz); end
      if (ob_done[c] !== 1'b0) begin errors++; $display("FAIL stop done cyc %0d got %b exp 0", c, ob_done[c]); end
      if (ob_state[c] !== m_state(e_b, e_bz)) begin
        errors++; $display("FAIL stop state cyc %0d got %0d exp %0d", c, ob_state[c], m_state(e_b, e_bz));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e_b, e_bz, e_d;
    kick(4'd1);
    observe(14, 5, 1'b1, 1'b0, 4'd1);
    for (int c = 1; c <= 14; c++) begin
      e_b  = m_beep(c, 1) | m_beep(c - 5, 1);
      e_bz = m_busy(c, 1) | m_busy(c - 5, 1);
      e_d  = m_done(c, 1) | m_done(c - 5, 1);
      checks += 3;
      if (ob_beep[c] !== e_b) begin errors++; $display("FAIL b2b beep cyc %0d got %b exp %b", c, ob_beep[c], e_b); end
      if (ob_busy[c] !== e_bz) begin errors++; $display("FAIL b2b busy cyc %0d got %b exp %b", c, ob_busy[c], e_bz); end
      if (ob_done[c] !== e_d) begin errors++; $display("FAIL b2b done cyc %0d got %b exp %b", c, ob_done[c], e_d); end
    end
  endtask

  task automatic test_reset_mid();
    logic e_b, e_bz;
    kick(4'd2);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      e_b  = (c <= 3) ? m_beep(c, 2) : 1'b0;
      e_bz = (c <= 3) ? m_busy(c, 2) : 1'b0;
      checks += 4;
      if (beep_out !== e_b) begin errors++; $display("FAIL rstmid beep cyc %0d got %b exp %b", c, beep_out, e_b); end
      if (busy !== e_bz) begin errors++; $display("FAIL rstmid busy cyc %0d got %b exp %b", c, busy, e_bz); end
      if (done !== 1'b0) begin errors++; $display("FAIL rstmid done cyc %0d got %b exp 0", c, done); end
      if (state_dbg !== m_state(e_b, e_bz)) begin
        errors++; $display("FAIL rstmid state cyc %0d got %0d exp %0d", c, state_dbg, m_state(e_b, e_bz));
      end
      if (c == 3) begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; num = 4'd7;
      end else if (c == 4) begin
        start = 1'b0; stop = 1'b1;
      end else if (c == 5) begin
        rst = 1'b0; start = 1'b0; stop = 1'b0;
      end
    end
    test_basic("after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    num    = 4'd0;
    test_reset();
    test_basic("basic");
    test_zero();
    test_ignore_start();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
